// File: rtl/frame_tick_timer.sv
// frame_tick_timer
// Programmable frame-rate tick generator. A down-counter reloads from a
// shadow period register and emits a registered one-cycle tick each time it
// expires, either periodically or once (one-shot). Ticks are counted in a
// wrapping frame counter. Period writes land in the shadow and take effect at
// the next reload (tick, start or stop); a write coincident with a reload is
// bypassed straight into the counter.
module frame_tick_timer #(
    parameter int          CNT_W      = 32,
    parameter int          FRAME_W    = 16,
    parameter int unsigned DEF_PERIOD = 833332,
    parameter bit          AUTOSTART  = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic               start,
    input  logic               stop,
    input  logic               oneshot,
    input  logic [CNT_W-1:0]   period_in,
    input  logic               period_load,
    input  logic               frame_clr,
    output logic               tick,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               busy
);

    localparam logic [CNT_W-1:0] DEF_CNT = CNT_W'(DEF_PERIOD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]   reload_val;
    logic               tick_q, tick_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               os_q, os_d;

    // A reload in the same cycle as a period write takes the new value.
    assign reload_val = period_load ? period_in : shadow_q;

    // Next-state, counter, tick and frame-count decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = period_load ? period_in : shadow_q;
        tick_d   = 1'b0;
        frame_d  = frame_q;
        os_d     = os_q;

        if (stop) begin
            // Stop has priority over start, and suppresses any pending tick.
            state_d = IDLE;
            cnt_d   = reload_val;
        end else if (start) begin
            // Restart discards whatever remains of the current period.
            state_d = RUN;
            cnt_d   = reload_val;
            os_d    = oneshot;
        end else begin
            case (state_q)
                IDLE: begin
                    // Keep the counter primed with the shadow while parked.
                    cnt_d = reload_val;
                end
                RUN: begin
                    if (enable) begin
                        if (cnt_q == '0) begin
                            tick_d  = 1'b1;
                            cnt_d   = reload_val;
                            frame_d = frame_q + FRAME_W'(1);
                            os_d    = oneshot;
                            if (os_q) begin
                                state_d = DONE;
                            end
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    // One-shot finished; wait for start or stop.
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Clear beats a coincident increment; the tick itself still fires.
        if (frame_clr) begin
            frame_d = '0;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= AUTOSTART ? RUN : IDLE;
            cnt_q    <= DEF_CNT;
            shadow_q <= DEF_CNT;
            tick_q   <= 1'b0;
            frame_q  <= '0;
            os_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            tick_q   <= tick_d;
            frame_q  <= frame_d;
            os_q     <= os_d;
        end
    end

    assign tick      = tick_q;
    assign frame_cnt = frame_q;
    assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_frame_tick_timer.sv
// Bench for frame_tick_timer: directed stimulus pushes the expected
// (cycle, frame_cnt) of every tick into a queue; an independent monitor pops
// and compares each time the DUT raises tick.
module tb_frame_tick_timer;

    logic       clk;
    logic       resetn;
    logic       enable;
    logic       start;
    logic       stop;
    logic       oneshot;
    logic [7:0] period_in;
    logic       period_load;
    logic       frame_clr;
    logic       tick;
    logic [3:0] frame_cnt;
    logic       busy;

    frame_tick_timer #(
        .CNT_W     (8),
        .FRAME_W   (4),
        .DEF_PERIOD(3),
        .AUTOSTART (1'b1)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .start      (start),
        .stop       (stop),
        .oneshot    (oneshot),
        .period_in  (period_in),
        .period_load(period_load),
        .frame_clr  (frame_clr),
        .tick       (tick),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    typedef struct {
        int       cyc;
        int       fc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int f);
        exp_t e;
        e.cyc = c;
        e.fc  = f;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every tick must match the next expected entry.
    always @(negedge clk) begin
        if (resetn === 1'b1 && tick === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_tick: tick=1 at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("tick_cycle", 64'(cyc), 64'(e.cyc));
                chk("tick_frame", 64'(frame_cnt), 64'(e.fc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int s;
        int r;
        resetn      = 1'b0;
        enable      = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        oneshot     = 1'b0;
        period_in   = 8'd0;
        period_load = 1'b0;
        frame_clr   = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tick", 64'(tick), 64'd0);
        chk("rst_frame", 64'(frame_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);

        // Autostart with default period 3: ticks 4, 8, 12 cycles after release.
        step();
        resetn = 1'b1;
        r = cyc;
        push(r + 4, 1);
        push(r + 8, 2);
        push(r + 12, 3);
        repeat (12) step();
        chk("t1_frame", 64'(frame_cnt), 64'd3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t1_stop_busy", 64'(busy), 64'd0);
        repeat (3) step();

        // Period 4 (bypassed at start), enable toggling: ticks 10 apart.
        period_in   = 8'd4;
        period_load = 1'b1;
        start       = 1'b1;
        s = cyc + 1;
        step();
        period_load = 1'b0;
        start       = 1'b0;
        push(s + 9, 4);
        push(s + 19, 5);
        for (int k = 0; k < 20; k++) begin
            enable = (((cyc + 1 - s) % 2) == 1);
            step();
        end
        enable = 1'b1;
        stop   = 1'b1;
        step();
        stop   = 1'b0;

        // Period write mid-period: current period (4) completes, then 10 apart.
        start = 1'b1;
        s = cyc + 1;
        step();
        start = 1'b0;
        step();
        period_in   = 8'd9;
        period_load = 1'b1;
        step();
        period_load = 1'b0;
        push(s + 5, 6);
        push(s + 15, 7);
        repeat (13) step();
        stop = 1'b1;
        step();
        stop = 1'b0;

        // One-shot, period 2: single tick 3 cycles after start, then DONE.
        period_in   = 8'd2;
        period_load = 1'b1;
        oneshot     = 1'b1;
        start       = 1'b1;
        s = cyc + 1;
        step();
        period_load = 1'b0;
        oneshot     = 1'b0;
        start       = 1'b0;
        push(s + 3, 8);
        step();
        step();
        chk("t4_run_busy", 64'(busy), 64'd1);
        repeat (8) step();
        chk("t4_done_busy", 64'(busy), 64'd0);
        chk("t4_frame", 64'(frame_cnt), 64'd8);

        // start+stop together on the expiring cycle: stop wins, no tick.
        start = 1'b1;
        s = cyc + 1;
        step();
        start = 1'b0;
        chk("t5_run_busy", 64'(busy), 64'd1);
        step();
        step();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_frame", 64'(frame_cnt), 64'd8);
        repeat (6) step();

        // frame_clr on the tick cycle: tick still fires, count becomes 0.
        start = 1'b1;
        s = cyc + 1;
        step();
        start = 1'b0;
        step();
        step();
        frame_clr = 1'b1;
        push(s + 3, 0);
        step();
        frame_clr = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t6_frame", 64'(frame_cnt), 64'd0);

        // Period 0: tick every cycle; 17 ticks wrap the 4-bit count to 1.
        period_in   = 8'd0;
        period_load = 1'b1;
        start       = 1'b1;
        s = cyc + 1;
        step();
        period_load = 1'b0;
        start       = 1'b0;
        for (int i = 1; i <= 17; i++) push(s + i, i % 16);
        repeat (17) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t7_frame", 64'(frame_cnt), 64'd1);
        chk("t7_busy", 64'(busy), 64'd0);

        // Asynchronous reset while tick is high; shadow reverts to 3.
        start = 1'b1;
        s = cyc + 1;
        step();
        start = 1'b0;
        push(s + 1, 2);
        push(s + 2, 3);
        push(s + 3, 4);
        repeat (3) step();
        @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("t8_tick", 64'(tick), 64'd0);
        chk("t8_frame", 64'(frame_cnt), 64'd0);
        chk("t8_busy", 64'(busy), 64'd1);
        step();
        resetn = 1'b1;
        r = cyc;
        push(r + 4, 1);
        push(r + 8, 2);
        repeat (8) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        repeat (4) step();

        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
